led_frame_sched: RTL and testbench
==================================

// Module: led_frame_sched
// PURPOSE
//  Frame scheduler for led_ctrl_top in the clk_fast (150M) domain. Generates start/en pulses
//  on a programmable frame period, holds a bank of 16-zone RGB444 patterns, and presents the
//  active pattern on MeanR/G/B, stable for a whole frame. Pattern changes only at frame boundaries.
// PARAMETERS
//  FRAME_CYC    3000000  frame period in clk_fast cycles (>= EN_OFS+2)
//  EN_OFS       2070000  cycles from start_o pulse to en_o pulse (>= 1)
//  NPAT         4        pattern bank depth (power of 2, >= 2)
//  HOLD_FRAMES  50       frames each pattern is shown in rotation mode (>= 1)
// PORTS
//  clk_fast   in   1                clock
//  rstn       in   1                async active-low reset
//  run        in   1                1 = schedule frames; 0 = stop after current frame
//  cfg_we     in   1                write cfg_data into bank[cfg_idx]
//  cfg_idx    in   $clog2(NPAT)     bank write index
//  cfg_data   in   192              pattern, zone i = [i*12+:12] = {R,G,B} 4b each
//  sel_idx    in   $clog2(NPAT)     static pattern select (rotation off)
//  start_o    out  1                1-cycle pulse, to led_ctrl_top.start
//  en_o       out  1                1-cycle pulse, to led_ctrl_top.en
//  MeanR/G/B  out  [3:0] x16 each   active pattern per zone
//  busy_o     out  1                frame in progress
//  frame_cnt_o out 16               completed frames, wraps 0xFFFF->0
// BEHAVIOUR
//  Reset: start_o=en_o=busy_o=0, frame_cnt_o=0, MeanR/G/B=0, bank=0, state IDLE, cur_idx=0.
//  FSM IDLE -> START (run=1) -> TXWAIT -> LATCH -> GAP -> START (run=1) | IDLE (run=0).
//  Frame counter fc counts 0..FRAME_CYC-1; fc=0 in START.
//  START: 1 cycle; start_o=1; active pattern <= bank[cur_idx] (registered, old bank value if
//   cfg_we hits same index same cycle -- read-before-write); MeanR/G/B update next cycle.
//  TXWAIT: until fc==EN_OFS-1. LATCH: en_o=1 one cycle (fc==EN_OFS).
//  GAP: until fc==FRAME_CYC-1; then frame_cnt_o+1, pattern index advance, next state.
//  start_o to start_o spacing exactly FRAME_CYC cycles while run=1; en_o follows start_o by EN_OFS.
//  run=0 mid-frame: frame completes incl. en_o and frame_cnt_o increment, then IDLE.
//  run re-asserted in IDLE: START next cycle, fc restarts at 0.
//  busy_o=1 in START/TXWAIT/LATCH/GAP.
//  cfg_we accepted any cycle, any state; never alters MeanR/G/B until next START.
//  start_o and en_o never asserted in the same cycle.
//  Async reset mid-frame: all outputs to reset values immediately; no partial en_o.
// CONFIGURATION
//  LED_SCHED_ROTATE_EN defined: hold counter counts completed frames; after HOLD_FRAMES
//   frames cur_idx <= cur_idx+1 (wraps NPAT-1 -> 0), hold counter clears; sel_idx ignored.
//   Counter preserved across run=0/1; cleared only by reset.
//  Not defined: cur_idx <= sel_idx sampled at each frame end and in IDLE; no hold counter.
// STRUCTURE
//  led_sched_pkg: rgb444_t {r,g,b}, pattern_t (rgb444_t [15:0]), NZONE=16,
//   sched_state_e {IDLE,START,TXWAIT,LATCH,GAP}, pack/unpack function 192b <-> pattern_t.
//  Sub-module led_frame_timer: fc counter with clear, outputs tick_en (fc==EN_OFS-1) and
//   tick_end (fc==FRAME_CYC-1); FSM, bank, rotation stay in led_frame_sched.
// TESTING (FRAME_CYC=100, EN_OFS=60, NPAT=4, HOLD_FRAMES=2)
//  Reset, run=1 at t0 -> start_o at t0+1, en_o at +60, next start_o at +100, frame_cnt_o=1.
//  cfg_we bank[0]=zone0 12'h742 mid-frame -> MeanR[0]=7,G=4,B=2 only after next start_o.
//  run=0 at fc=30 -> en_o still at fc=60, frame_cnt_o+1, busy_o=0, no further start_o.
//  ROTATE_EN, bank[k]=distinct -> idx 0,0,1,1,2,2,3,3,0 over 9 frames.
//  No ROTATE_EN, sel_idx 0->2 at fc=10 -> MeanR/G/B = bank[2] from next frame.
//  rstn low at fc=50 -> all outputs 0 at once; after release, run=1 -> clean frame from fc=0.

Source files
------------

// File: rtl/led_frame_sched_pkg.sv
// Shared types for the LED frame scheduler: zone colour, 16-zone pattern, FSM states.
// Pure declarations and helpers, no timing or flow control.
package led_sched_pkg;

    localparam int NZONE = 16;
    localparam int PAT_W = NZONE * 12;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb444_t;

    typedef rgb444_t [NZONE-1:0] pattern_t;

    typedef enum logic [2:0] {IDLE, START, TXWAIT, LATCH, GAP} sched_state_e;

    function automatic pattern_t unpack_pattern(input logic [PAT_W-1:0] d);
        pattern_t p;
        for (int i = 0; i < NZONE; i++) begin
            p[i] = rgb444_t'(d[i*12 +: 12]);
        end
        return p;
    endfunction

    function automatic logic [PAT_W-1:0] pack_pattern(input pattern_t p);
        logic [PAT_W-1:0] d;
        for (int i = 0; i < NZONE; i++) begin
            d[i*12 +: 12] = p[i];
        end
        return d;
    endfunction

endpackage

// File: rtl/led_frame_sched_if.sv
// Control/config inputs and frame outputs of the LED frame scheduler.
// master drives run/cfg/sel; slave (the scheduler) drives pulses, status and zone colours.
interface led_sched_if #(
    parameter int NPAT = 4
) ();
    import led_sched_pkg::*;

    localparam int IW = $clog2(NPAT);

    logic                       run;
    logic                       cfg_we;
    logic [IW-1:0]              cfg_idx;
    logic [PAT_W-1:0]           cfg_data;
    logic [IW-1:0]              sel_idx;
    logic                       start_o;
    logic                       en_o;
    logic                       busy_o;
    logic [15:0]                frame_cnt_o;
    logic [NZONE-1:0][3:0]      MeanR;
    logic [NZONE-1:0][3:0]      MeanG;
    logic [NZONE-1:0][3:0]      MeanB;

    modport master (
        output run, cfg_we, cfg_idx, cfg_data, sel_idx,
        input  start_o, en_o, busy_o, frame_cnt_o, MeanR, MeanG, MeanB
    );

    modport slave (
        input  run, cfg_we, cfg_idx, cfg_data, sel_idx,
        output start_o, en_o, busy_o, frame_cnt_o, MeanR, MeanG, MeanB
    );
endinterface

// File: rtl/led_frame_sched_timer.sv
// Frame position counter: fc runs 0..FRAME_CYC-1 and wraps, held at 0 while clr.
// Ticks are combinational decodes of fc; no backpressure.
module led_frame_timer #(
    parameter int FRAME_CYC = 3000000,
    parameter int EN_OFS    = 2070000
) (
    input  logic clk_fast,
    input  logic rstn,
    input  logic clr,
    output logic tick_en,
    output logic tick_end
);
    localparam int FW = $clog2(FRAME_CYC);
    localparam logic [FW-1:0] LAST   = FW'(FRAME_CYC - 1);
    localparam logic [FW-1:0] EN_PRE = FW'(EN_OFS - 1);

    logic [FW-1:0] fc;

    always_ff @(posedge clk_fast or negedge rstn) begin
        if (!rstn) begin
            fc <= '0;
        end else if (clr || fc == LAST) begin
            fc <= '0;
        end else begin
            fc <= fc + 1'b1;
        end
    end

    assign tick_en  = (fc == EN_PRE);
    assign tick_end = (fc == LAST);
endmodule

// File: rtl/led_frame_sched.sv
// Frame scheduler: start_o/en_o pulses per frame, pattern bank, active pattern held per frame.
// start_o one cycle after run seen in IDLE; pattern visible one cycle after start_o; no backpressure.
// Define LED_SCHED_ROTATE_EN to rotate through the bank every HOLD_FRAMES frames instead of sel_idx.
module led_frame_sched
    import led_sched_pkg::*;
#(
    parameter int FRAME_CYC   = 3000000,
    parameter int EN_OFS      = 2070000,
    parameter int NPAT        = 4,
    parameter int HOLD_FRAMES = 50
) (
    input  logic        clk_fast,
    input  logic        rstn,
    led_sched_if.slave  sif
);
    localparam int IW = $clog2(NPAT);

    if (FRAME_CYC < EN_OFS + 2 || EN_OFS < 1 || HOLD_FRAMES < 1 ||
        NPAT < 2 || (NPAT & (NPAT - 1)) != 0) begin : g_bad_cfg
        $error("led_frame_sched: illegal parameter set");
    end

    sched_state_e  state;
    pattern_t      bank [NPAT];
    pattern_t      act;
    logic [IW-1:0] cur_idx;
    logic          tick_en;
    logic          tick_end;

`ifdef LED_SCHED_ROTATE_EN
    localparam int HW = $clog2(HOLD_FRAMES + 1);
    logic [HW-1:0] hold_cnt;
`endif

    led_frame_timer #(
        .FRAME_CYC (FRAME_CYC),
        .EN_OFS    (EN_OFS)
    ) u_timer (
        .clk_fast  (clk_fast),
        .rstn      (rstn),
        .clr       (state == IDLE),
        .tick_en   (tick_en),
        .tick_end  (tick_end)
    );

    always_ff @(posedge clk_fast or negedge rstn) begin
        if (!rstn) begin
            state           <= IDLE;
            sif.start_o     <= 1'b0;
            sif.en_o        <= 1'b0;
            sif.busy_o      <= 1'b0;
            sif.frame_cnt_o <= '0;
            act             <= '0;
            cur_idx         <= '0;
`ifdef LED_SCHED_ROTATE_EN
            hold_cnt        <= '0;
`endif
            for (int i = 0; i < NPAT; i++) begin
                bank[i] <= '0;
            end
        end else begin
            sif.start_o <= 1'b0;
            sif.en_o    <= 1'b0;
            // Same-cycle read of bank in START sees the pre-write value.
            if (sif.cfg_we) begin
                bank[sif.cfg_idx] <= unpack_pattern(sif.cfg_data);
            end
            case (state)
                IDLE: begin
`ifndef LED_SCHED_ROTATE_EN
                    cur_idx <= sif.sel_idx;
`endif
                    if (sif.run) begin
                        state       <= START;
                        sif.start_o <= 1'b1;
                        sif.busy_o  <= 1'b1;
                    end
                end
                START: begin
                    act <= bank[cur_idx];
                    if (tick_en) begin
                        state    <= LATCH;
                        sif.en_o <= 1'b1;
                    end else begin
                        state <= TXWAIT;
                    end
                end
                TXWAIT: begin
                    if (tick_en) begin
                        state    <= LATCH;
                        sif.en_o <= 1'b1;
                    end
                end
                LATCH: state <= GAP;
                GAP: begin
                    if (tick_end) begin
                        sif.frame_cnt_o <= sif.frame_cnt_o + 16'd1;
`ifdef LED_SCHED_ROTATE_EN
                        if (hold_cnt == HW'(HOLD_FRAMES - 1)) begin
                            hold_cnt <= '0;
                            cur_idx  <= cur_idx + 1'b1;
                        end else begin
                            hold_cnt <= hold_cnt + 1'b1;
                        end
`else
                        cur_idx <= sif.sel_idx;
`endif
                        if (sif.run) begin
                            state       <= START;
                            sif.start_o <= 1'b1;
                        end else begin
                            state      <= IDLE;
                            sif.busy_o <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        sif.MeanR = '0;
        sif.MeanG = '0;
        sif.MeanB = '0;
        for (int z = 0; z < NZONE; z++) begin
            sif.MeanR[z] = act[z].r;
            sif.MeanG[z] = act[z].g;
            sif.MeanB[z] = act[z].b;
        end
    end
endmodule

// File: tb/tb_led_frame_sched.sv
// Randomized bench for led_frame_sched: stimulus pushes expected frame events, a monitor pops and compares.
module tb_led_frame_sched;
    localparam int FRAME = 100;
    localparam int ENO   = 60;
    localparam int NPAT  = 4;
    localparam int HOLD  = 2;

    typedef struct {
        int           cyc;
        int           fcnt;
        logic [191:0] pat;
    } sev_t;

    logic clk_fast = 1'b0;
    logic rstn     = 1'b0;
    always #5 clk_fast = ~clk_fast;

    led_sched_if #(.NPAT(NPAT)) sif ();

    led_frame_sched #(
        .FRAME_CYC   (FRAME),
        .EN_OFS      (ENO),
        .NPAT        (NPAT),
        .HOLD_FRAMES (HOLD)
    ) dut (
        .clk_fast (clk_fast),
        .rstn     (rstn),
        .sif      (sif)
    );

    int           cyc = 0;
    int           chk_total = 0;
    int           chk_bad = 0;
    sev_t         start_q[$];
    int           en_q[$];
    logic [191:0] bank_m [NPAT];
    int           sel_m = 0;
    int           done_frames = 0;
    int           mean_due = -1;
    logic [191:0] mean_exp = '0;
    logic [191:0] cur_pat = '0;

    always @(posedge clk_fast) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [191:0] got, input logic [191:0] exp);
        chk_total++;
        if (got !== exp) begin
            chk_bad++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, got, exp);
        end
    endtask

    task automatic flag(input string nm);
        chk_total++;
        chk_bad++;
        $display("FAIL %s at cycle %0d", nm, cyc);
    endtask

    function automatic logic [191:0] dut_pat();
        logic [191:0] p;
        p = '0;
        for (int i = 0; i < 16; i++) p[i*12 +: 12] = {sif.MeanR[i], sif.MeanG[i], sif.MeanB[i]};
        return p;
    endfunction

    function automatic logic [191:0] rnd_pat();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    // Displayed index as a function of completed frames (rotation) or the last sampled select.
    function automatic int exp_idx();
`ifdef LED_SCHED_ROTATE_EN
        return (done_frames / HOLD) % NPAT;
`else
        return sel_m;
`endif
    endfunction

    task automatic push_frame(input int at);
        start_q.push_back('{at, done_frames & 32'hFFFF, bank_m[exp_idx()]});
        en_q.push_back(at + ENO);
    endtask

    task automatic step();
        @(negedge clk_fast);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_start"}, sif.start_o, 0);
        check({tag, "_en"}, sif.en_o, 0);
        check({tag, "_busy"}, sif.busy_o, 0);
        check({tag, "_fcnt"}, sif.frame_cnt_o, 0);
        check({tag, "_mean"}, dut_pat(), 0);
    endtask

    task automatic write_bank(input int idx, input logic [191:0] d);
        sif.cfg_we   = 1'b1;
        sif.cfg_idx  = idx[1:0];
        sif.cfg_data = d;
        bank_m[idx]  = d;
    endtask

    task automatic session(input int nframes, input int reset_frame);
        int s;
        int sf;
        int stop_fc;
        logic [191:0] d;
        step();
        sif.run = 1'b1;
        s = cyc + 1;
        push_frame(s);
        stop_fc = $urandom_range(0, FRAME - 2);
        for (int f = 0; f < nframes; f++) begin
            sf = s + f * FRAME;
            for (int fc = 0; fc < FRAME; fc++) begin
                step();
                sif.cfg_we = 1'b0;
                if (f == reset_frame && fc == 50) begin
                    rstn = 1'b0;
                    sif.run = 1'b0;
                    start_q.delete();
                    en_q.delete();
                    mean_due = -1;
                    cur_pat = '0;
                    done_frames = 0;
                    foreach (bank_m[i]) bank_m[i] = '0;
                    #1;
                    check_zero("async_reset");
                    step();
                    step();
                    rstn = 1'b1;
                    step();
                    check_zero("after_reset");
                    return;
                end
                if (f == 0 && fc == 20) begin
                    d = rnd_pat();
                    d[11:0] = 12'h742;
                    write_bank(0, d);
                end else if (fc == 0) begin
                    write_bank(exp_idx(), rnd_pat());
                end else if ($urandom_range(0, 7) == 0) begin
                    write_bank($urandom_range(0, NPAT - 1), rnd_pat());
                end
                if ((fc == 10 || fc == FRAME - 1) && $urandom_range(0, 1) == 1) begin
                    sel_m = $urandom_range(0, NPAT - 1);
                    sif.sel_idx = sel_m[1:0];
                end
                if (f == nframes - 1 && fc == stop_fc) sif.run = 1'b0;
                if (fc == FRAME - 1) begin
                    done_frames++;
                    if (f != nframes - 1) push_frame(sf + FRAME);
                end
            end
        end
        step();
        sif.cfg_we = 1'b0;
        check("busy_after_stop", sif.busy_o, 0);
        check("fcnt_after_stop", sif.frame_cnt_o, done_frames & 32'hFFFF);
        check("start_q_drained", start_q.size(), 0);
        check("en_q_drained", en_q.size(), 0);
    endtask

    initial begin : monitor
        sev_t e;
        logic [191:0] p;
        forever begin
            @(negedge clk_fast);
            #1;
            if (rstn) begin
                p = dut_pat();
                if (sif.start_o && sif.en_o) flag("start_en_overlap");
                if (mean_due == cyc) begin
                    check("mean_after_start", p, mean_exp);
                    cur_pat = mean_exp;
                    mean_due = -1;
                end
                if (sif.start_o) begin
                    if (start_q.size() == 0) begin
                        flag("unexpected_start");
                    end else begin
                        e = start_q.pop_front();
                        check("start_cycle", cyc, e.cyc);
                        check("fcnt_at_start", sif.frame_cnt_o, e.fcnt);
                        check("busy_at_start", sif.busy_o, 1);
                        mean_exp = e.pat;
                        mean_due = cyc + 1;
                    end
                end else if (start_q.size() != 0 && start_q[0].cyc < cyc) begin
                    flag("missing_start");
                    void'(start_q.pop_front());
                end
                if (sif.en_o) begin
                    if (en_q.size() == 0) begin
                        flag("unexpected_en");
                    end else begin
                        check("en_cycle", cyc, en_q.pop_front());
                        check("mean_stable_at_en", p, cur_pat);
                    end
                end else if (en_q.size() != 0 && en_q[0] < cyc) begin
                    flag("missing_en");
                    void'(en_q.pop_front());
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $display("test done: total=%0d bad=%0d", chk_total, chk_bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        sif.run      = 1'b0;
        sif.cfg_we   = 1'b0;
        sif.cfg_idx  = '0;
        sif.cfg_data = '0;
        sif.sel_idx  = '0;
        foreach (bank_m[i]) bank_m[i] = '0;
        repeat (3) step();
        check_zero("in_reset");
        rstn = 1'b1;
        step();
        check_zero("idle_after_reset");
        session(3, -1);
        repeat ($urandom_range(3, 40)) step();
        session(2, -1);
        repeat ($urandom_range(3, 40)) step();
        session(9, -1);
        repeat ($urandom_range(3, 40)) step();
        session(3, 1);
        repeat ($urandom_range(3, 40)) step();
        session(2, -1);
        repeat (150) step();
        check("final_start_q", start_q.size(), 0);
        check("final_en_q", en_q.size(), 0);
        $display("test done: total=%0d bad=%0d", chk_total, chk_bad);
        $finish;
    end
endmodule
